square_shift_add: RTL and testbench

SQUARE_SHIFT_ADD -- requirements
Module: square_shift_add

---
 rtl/square_pkg.sv | 15 +
 rtl/square_shift_add.sv | 98 +++++++++
 tb/tb_square_shift_add.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/square_pkg.sv
// Shared definitions for the square_shift_add block: the FSM state
// encoding and the default operand width.
package square_pkg;

    // Operand width used when the instantiating module does not override it.
    localparam int DEFAULT_WIDTH = 16;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : square_pkg

// File: rtl/square_shift_add.sv
// square_shift_add: unsigned x*x by iterative shift-and-add, one multiplier
// bit per clock. A holds the shifting multiplicand, B the shifting
// multiplier, and the accumulator is full 2*WIDTH bits wide, so no
// truncation occurs.
//
// Build option: define SQUARE_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero. Without it, latency is always
// WIDTH cycles. The product is the same in both builds.
module square_shift_add
    import square_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    // Counter must be able to represent WIDTH itself.
    localparam int CW = $clog2(WIDTH) + 1;

    state_t               state;
    logic [2*WIDTH-1:0]   a;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     b;
    logic [CW-1:0]        cnt;

    logic [2*WIDTH-1:0]   sum;
    logic [WIDTH-1:0]     b_next;
    logic                 last;

    // One add/shift step: conditional add of A, then B moves down one bit.
    assign sum    = b[0] ? (acc + a) : acc;
    assign b_next = b >> 1;

`ifdef SQUARE_EARLY_EXIT_EN
    // Stop on the last bit, or as soon as no set multiplier bits remain.
    assign last = (cnt == CW'(WIDTH - 1)) || (b_next == '0);
`else
    // Stop only after all WIDTH multiplier bits have been consumed.
    assign last = (cnt == CW'(WIDTH - 1));
`endif

    assign busy = (state != IDLE);

    // Controller and datapath registers, with the done pulse and result registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all state uses non-blocking assignments so that every
            // register samples values from before the edge, independent of
            // statement order.
            state  <= IDLE;
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a     <= {{WIDTH{1'b0}}, x};
                        b     <= x;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= sum;
                    a   <= a << 1;
                    b   <= b_next;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        result <= sum;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : square_shift_add

// File: tb/tb_square_shift_add.sv
// Directed self-checking bench for square_shift_add (WIDTH = 16).
// Expected latencies follow the SQUARE_EARLY_EXIT_EN build option.
module tb_square_shift_add;

    localparam int W = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start;
    logic [W-1:0]       x;
    logic               busy;
    logic               done;
    logic [2*W-1:0]     result;

    int passed = 0;
    int total  = 0;

    square_shift_add #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .x      (x),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Expected cycles from the accepting edge to the done pulse.
    function automatic int exp_lat(input logic [W-1:0] v);
        int msb;
        msb = 0;
        for (int i = 0; i < W; i++)
            if (v[i]) msb = i;
`ifdef SQUARE_EARLY_EXIT_EN
        return msb + 1;
`else
        return W;
`endif
    endfunction

    // Launch one operation, then scramble x and observe a fixed window.
    // Returns the latency of the first done pulse (-1 if none), the result
    // captured at that pulse, and the number of cycles with done high.
    task automatic run_op(input logic [W-1:0] v, output int lat,
                          output logic [2*W-1:0] res, output int pulses);
        @(negedge clk);
        x = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x = ~v;
        lat = -1;
        res = '0;
        pulses = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat = n;
                    res = result;
                end
            end
        end
    endtask

    task automatic test_reset();
        start = 1'b0;
        x = '0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else passed++;
        total++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done);
        else passed++;
        total++;
        if (result !== '0) $display("FAIL reset_result: got %h want 0", result);
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL idle_after_reset: busy got %b want 0", busy);
        else passed++;
    endtask

    task automatic test_square(input string name, input logic [W-1:0] v,
                               input logic [2*W-1:0] want);
        int lat, pulses;
        logic [2*W-1:0] res;
        run_op(v, lat, res, pulses);
        total++;
        if (res !== want) $display("FAIL %s_result: got %h want %h", name, res, want);
        else passed++;
        total++;
        if (lat != exp_lat(v)) $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat(v));
        else passed++;
        total++;
        if (pulses != 1) $display("FAIL %s_pulses: got %0d want 1", name, pulses);
        else passed++;
        total++;
        if (result !== want) $display("FAIL %s_result_hold: got %h want %h", name, result, want);
        else passed++;
    endtask

    task automatic test_ignore_start();
        int pulses, lat;
        logic [2*W-1:0] res;
        @(negedge clk);
        x = 16'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pulses = 0;
        lat = -1;
        res = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                start = 1'b1;
                x = 16'd9;
            end else if (n == 2) begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat = n;
                    res = result;
                end
            end
        end
        total++;
        if (res !== 32'd9) $display("FAIL ignore_result: got %0d want 9", res);
        else passed++;
        total++;
        if (pulses != 1) $display("FAIL ignore_pulses: got %0d want 1", pulses);
        else passed++;
        total++;
        if (lat != exp_lat(16'd3)) $display("FAIL ignore_latency: got %0d want %0d", lat, exp_lat(16'd3));
        else passed++;
    endtask

    task automatic test_abort();
        int pulses;
        @(negedge clk);
        x = 16'd200;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy);
        else passed++;
        total++;
        if (done !== 1'b0) $display("FAIL abort_done: got %b want 0", done);
        else passed++;
        total++;
        if (result !== '0) $display("FAIL abort_result: got %h want 0", result);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        total++;
        if (pulses != 0) $display("FAIL abort_no_done: active cycles got %0d want 0", pulses);
        else passed++;
        test_square("after_abort_x7", 16'd7, 32'd49);
    endtask

    task automatic test_back_to_back();
        int p1, p2, unstable, idle_busy;
        logic [2*W-1:0] r1, r2;
        @(negedge clk);
        x = 16'd2;
        start = 1'b1;
        @(posedge clk);
        p1 = -1;
        p2 = -1;
        r1 = '0;
        r2 = '0;
        unstable = 0;
        idle_busy = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) x = 16'd4;
            if (p1 >= 0 && p2 < 0 && !done && result !== 32'd4) unstable++;
            if (p1 >= 0 && n == p1 + 1) idle_busy = busy;
            if (done) begin
                if (p1 < 0) begin
                    p1 = n;
                    r1 = result;
                end else if (p2 < 0) begin
                    p2 = n;
                    r2 = result;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        total++;
        if (r1 !== 32'd4) $display("FAIL b2b_result1: got %0d want 4", r1);
        else passed++;
        total++;
        if (r2 !== 32'd16) $display("FAIL b2b_result2: got %0d want 16", r2);
        else passed++;
        total++;
        if (p1 != exp_lat(16'd2)) $display("FAIL b2b_latency1: got %0d want %0d", p1, exp_lat(16'd2));
        else passed++;
        total++;
        if (p2 - p1 != 2 + exp_lat(16'd4))
            $display("FAIL b2b_gap: got %0d want %0d", p2 - p1, 2 + exp_lat(16'd4));
        else passed++;
        total++;
        if (idle_busy !== 1'b0) $display("FAIL b2b_idle_cycle: busy got %b want 0", idle_busy);
        else passed++;
        total++;
        if (unstable != 0) $display("FAIL b2b_result_stable: changed cycles got %0d want 0", unstable);
        else passed++;
    endtask

    initial begin
        start = 1'b0;
        x = '0;
        test_reset();
        test_square("x5", 16'd5, 32'd25);
        test_square("x0", 16'd0, 32'd0);
        test_square("xffff", 16'hFFFF, 32'hFFFE0001);
        test_square("x8000", 16'h8000, 32'h40000000);
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_square_shift_add
